// File: rtl/pin_cond_pkg.sv
// Shared definitions for the push-button / slide-switch input conditioner.
package pin_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_e;

  // io_in indices of the conditioned pins on the board top level.
  localparam int PIN_BUTTON = 10;
  localparam int PIN_SWITCH = 11;

endpackage

// File: rtl/pin_input_conditioner_debounce_channel.sv
// One input pin: synchroniser chain, debounce FSM, registered level and rise/fall pulses.
module debounce_channel
  import pin_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_chain_d[gi] = raw;
    end else begin : g_rest
      assign sync_chain_d[gi] = sync_chain_q[gi-1];
    end
  end

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (sync_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_chain_q <= '0;
      state_q      <= STABLE_LOW;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pin_input_conditioner.sv
// Conditions the board button and switch pins and keeps an up/down press counter
// whose direction follows the debounced switch.
module pin_input_conditioner
  import pin_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   button_raw,
  input  logic                   switch_raw,
  output logic                   button_level,
  output logic                   button_press,
  output logic                   button_release,
  output logic                   switch_level,
  output logic                   switch_change,
  output logic [COUNT_WIDTH-1:0] press_count
);

  logic                   switch_rise, switch_fall;
  logic [COUNT_WIDTH-1:0] press_count_q, press_count_d;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (button_raw),
    .level(button_level),
    .rise (button_press),
    .fall (button_release)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (switch_raw),
    .level(switch_level),
    .rise (switch_rise),
    .fall (switch_fall)
  );

  assign switch_change = switch_rise | switch_fall;

  // Direction is taken from the level present alongside the press pulse, so a
  // switch settling on the same edge as the press already steers it.
  always_comb begin
    press_count_d = press_count_q;
    if (button_press) begin
      if (switch_level) press_count_d = press_count_q + COUNT_WIDTH'(1);
      else              press_count_d = press_count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) press_count_q <= '0;
    else        press_count_q <= press_count_d;
  end

  assign press_count = press_count_q;

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_pin_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       button_raw, switch_raw;
  logic       button_level, button_press, button_release;
  logic       switch_level, switch_change;
  logic [9:0] press_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pin_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_raw    (button_raw),
    .switch_raw    (switch_raw),
    .button_level  (button_level),
    .button_press  (button_press),
    .button_release(button_release),
    .switch_level  (switch_level),
    .switch_change (switch_change),
    .press_count   (press_count)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Full press/release of the button; raw changes one cycle before the first sampling edge.
  task automatic do_press(input logic [9:0] exp_count);
    button_raw = 1'b1;
    tick(5);
    chk("press_early", {31'd0, button_press}, 32'd0);
    tick(1);
    chk("press_pulse", {31'd0, button_press}, 32'd1);
    chk("press_level", {31'd0, button_level}, 32'd1);
    tick(1);
    chk("press_one_cycle", {31'd0, button_press}, 32'd0);
    chk("press_count", {22'd0, press_count}, {22'd0, exp_count});
    button_raw = 1'b0;
    tick(6);
    chk("release_pulse", {31'd0, button_release}, 32'd1);
    chk("release_level", {31'd0, button_level}, 32'd0);
    tick(1);
    chk("release_count", {22'd0, press_count}, {22'd0, exp_count});
  endtask

  initial begin
    logic saw_press;
    rst_n      = 1'b0;
    button_raw = 1'b1;
    switch_raw = 1'b1;

    // Reset held for three edges with both raw pins high.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_button_level", {31'd0, button_level}, 32'd0);
      chk("rst_switch_level", {31'd0, switch_level}, 32'd0);
      chk("rst_press", {31'd0, button_press}, 32'd0);
      chk("rst_count", {22'd0, press_count}, 32'd0);
    end
    rst_n = 1'b1;
    tick(5);  // edges 0..4
    chk("post_rst_edge4_level", {31'd0, button_level}, 32'd0);
    tick(1);  // edge 5
    chk("post_rst_edge5_level", {31'd0, button_level}, 32'd1);
    chk("post_rst_edge5_press", {31'd0, button_press}, 32'd1);
    chk("post_rst_sw_change", {31'd0, switch_change}, 32'd1);
    tick(1);
    chk("post_rst_press_gone", {31'd0, button_press}, 32'd0);
    chk("post_rst_count", {22'd0, press_count}, 32'd1);

    // Release the button held since reset.
    button_raw = 1'b0;
    tick(6);
    chk("rel0_pulse", {31'd0, button_release}, 32'd1);
    tick(1);
    chk("rel0_count", {22'd0, press_count}, 32'd1);

    // Clean press with switch high: count up.
    do_press(10'd2);

    // Glitch of three raw cycles must be rejected.
    button_raw = 1'b1;
    tick(3);
    button_raw = 1'b0;
    saw_press = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (button_press || button_level) saw_press = 1'b1;
    end
    chk("glitch_no_press", {31'd0, saw_press}, 32'd0);
    chk("glitch_count", {22'd0, press_count}, 32'd2);

    // Switch low: count down through zero to wrap.
    switch_raw = 1'b0;
    tick(6);
    chk("sw_fall_change", {31'd0, switch_change}, 32'd1);
    chk("sw_fall_level", {31'd0, switch_level}, 32'd0);
    tick(1);
    chk("sw_change_gone", {31'd0, switch_change}, 32'd0);
    do_press(10'd1);
    do_press(10'd0);
    do_press(10'd1023);

    // Switch high: wrap back up to zero.
    switch_raw = 1'b1;
    tick(7);
    do_press(10'd0);

    // Switch low again, then switch and button settle on the same edge.
    switch_raw = 1'b0;
    tick(7);
    chk("simul_pre_level", {31'd0, switch_level}, 32'd0);
    switch_raw = 1'b1;
    button_raw = 1'b1;
    tick(6);
    chk("simul_press", {31'd0, button_press}, 32'd1);
    chk("simul_change", {31'd0, switch_change}, 32'd1);
    chk("simul_sw_level", {31'd0, switch_level}, 32'd1);
    tick(1);
    chk("simul_count_up", {22'd0, press_count}, 32'd1);
    button_raw = 1'b0;
    tick(7);

    // Reset one edge before the press would be accepted.
    button_raw = 1'b1;
    tick(4);  // edges k..k+3
    rst_n = 1'b0;
    tick(1);  // edge k+4
    chk("midrst_level", {31'd0, button_level}, 32'd0);
    chk("midrst_count", {22'd0, press_count}, 32'd0);
    rst_n = 1'b1;
    tick(1);  // edge k+5, first post-reset edge
    chk("midrst_no_press_k5", {31'd0, button_press}, 32'd0);
    tick(4);  // post-reset edges 1..4
    chk("midrst_edge4_press", {31'd0, button_press}, 32'd0);
    tick(1);  // post-reset edge 5
    chk("midrst_edge5_press", {31'd0, button_press}, 32'd1);
    tick(1);
    chk("midrst_count_after", {22'd0, press_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
